// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction fetch stage. Issues one instruction-memory request
//             at a time, buffers returned words in a 2-entry {instr, pc}
//             FIFO for decode, and handles branch/jump redirects. Data for a
//             request that is in flight when a redirect arrives is dropped.
//  Options  : IF_STALL_CNT_EN - adds a 32-bit saturating stall_cnt output
//             counting cycles where decode holds off a valid head.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // r_pc is the address of the live request (REQ) or the next one to issue.
  // r_old_addr keeps the abandoned address visible on the bus in DISCARD.
  logic [31:0] r_pc;
  logic [31:0] r_old_addr;

  logic        r_head_valid;
  logic [31:0] r_head_instr;
  logic [31:0] r_head_pc;
  logic        r_tail_valid;
  logic [31:0] r_tail_instr;
  logic [31:0] r_tail_pc;

  logic        w_ack;
  logic        w_pop;
  logic        w_push;
  logic [31:0] w_target;
  logic [1:0]  w_count_after;

  assign imem_req   = (r_state != S_IDLE);
  assign imem_addr  = (r_state == S_DISCARD) ? r_old_addr : r_pc;
  assign out_valid  = r_head_valid;
  assign out_instr  = r_head_instr;
  assign out_pc     = r_head_pc;
  assign out_opcode = r_head_instr[6:0];

  // An ack only counts while a request is actually on the bus.
  assign w_ack    = imem_ack && imem_req;
  assign w_pop    = r_head_valid && out_ready;
  assign w_push   = w_ack && (r_state == S_REQ) && !redirect_valid;
  assign w_target = {redirect_pc[31:2], 2'b00};

  // Occupancy after this cycle's push and pop (never exceeds 2).
  always_comb begin
    w_count_after = {1'b0, r_head_valid} + {1'b0, r_tail_valid}
                  + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Next-state logic for the request FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid || (w_count_after < 2'd2)) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_next_state = w_ack ? S_REQ : S_DISCARD;
        end else if (w_ack) begin
          w_next_state = (w_count_after < 2'd2) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (w_ack) begin
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Fetch address tracking: redirect wins, otherwise advance on each push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_old_addr <= 32'h0000_0000;
    end else if (redirect_valid) begin
      if ((r_state == S_REQ) && !w_ack) begin
        r_old_addr <= r_pc;
      end
      r_pc <= w_target;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Two-entry FIFO; a redirect flushes it while the head data is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_valid <= 1'b0;
      r_head_instr <= 32'h0000_0000;
      r_head_pc    <= 32'h0000_0000;
      r_tail_valid <= 1'b0;
      r_tail_instr <= 32'h0000_0000;
      r_tail_pc    <= 32'h0000_0000;
    end else if (redirect_valid) begin
      r_head_valid <= 1'b0;
      r_tail_valid <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_tail_valid) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_tail_instr <= imem_rdata;
            r_tail_pc    <= r_pc;
          end else begin
            r_head_instr <= imem_rdata;
            r_head_pc    <= r_pc;
          end
        end
        2'b01: begin
          if (r_tail_valid) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_tail_valid <= 1'b0;
          end else begin
            r_head_valid <= 1'b0;
          end
        end
        2'b10: begin
          if (!r_head_valid) begin
            r_head_valid <= 1'b1;
            r_head_instr <= imem_rdata;
            r_head_pc    <= r_pc;
          end else begin
            r_tail_valid <= 1'b1;
            r_tail_instr <= imem_rdata;
            r_tail_pc    <= r_pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  assign stall_cnt = r_stall_cnt;

  // Count cycles where a valid head waits on decode; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'h0000_0000;
    end else if (r_head_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage: directed vector table,
//             redirect/stall corner sequences, and random traffic against a
//             queue-based reference model. A second instance checks the
//             fetch-address wrap from RESET_PC = 32'hFFFF_FFFC.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;

  logic        wrap_req;
  logic [31:0] wrap_addr;
  logic        wrap_valid;
  logic [31:0] wrap_instr;
  logic [31:0] wrap_pc;
  logic [6:0]  wrap_opcode;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] wrap_stall_cnt;
`endif

  if_stage #(.RESET_PC(RESET_PC)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  // Memory for the wrap instance acknowledges whatever is requested.
  if_stage #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (wrap_req),
    .imem_addr      (wrap_addr),
    .imem_ack       (wrap_req),
    .imem_rdata     (32'h0000_0013),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0000_0000),
    .out_valid      (wrap_valid),
    .out_ready      (1'b1),
    .out_instr      (wrap_instr),
    .out_pc         (wrap_pc),
    .out_opcode     (wrap_opcode)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt      (wrap_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  bit          m_known = 1'b0;
  bit          m_pend;
  bit          m_drop;
  logic [31:0] m_fpc;
  logic [31:0] m_paddr;
  ent_t        m_shown;
  logic [31:0] m_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[26:2] ^ 25'h0A5_5A5A, 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("req", {31'd0, imem_req}, {31'd0, m_pend});
    if (m_pend) check("addr", imem_addr, m_paddr);
    check("valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0)});
    check("instr", out_instr, m_shown.instr);
    check("pc", out_pc, m_shown.pc);
    check("opcode", {25'd0, out_opcode}, {25'd0, m_shown.instr[6:0]});
`ifdef IF_STALL_CNT_EN
    check("stall", stall_cnt, m_stall);
`endif
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    bit          valid;
    bit          pop;
    bit          ackd;
    logic [31:0] tgt;
    ent_t        e;
    if (rst) begin
      m_q.delete();
      m_pend  = 1'b0;
      m_drop  = 1'b0;
      m_fpc   = RESET_PC;
      m_paddr = RESET_PC;
      m_shown = '0;
      m_stall = 32'd0;
      m_known = 1'b1;
    end else begin
      valid = (m_q.size() != 0);
      pop   = valid && out_ready;
      ackd  = m_pend && imem_ack;
      if (valid && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      tgt = redirect_pc & ~32'h3;
      if (redirect_valid) begin
        m_q.delete();
        if (m_pend && !ackd) begin
          m_drop = 1'b1;
          m_fpc  = tgt;
        end else begin
          m_pend  = 1'b1;
          m_drop  = 1'b0;
          m_fpc   = tgt;
          m_paddr = tgt;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (ackd) begin
          if (!m_drop) begin
            e.instr = imem_rdata;
            e.pc    = m_paddr;
            m_q.push_back(e);
            m_fpc = m_paddr + 32'd4;
          end
          m_drop = 1'b0;
          m_pend = 1'b0;
        end
        if (!m_pend && (m_q.size() < 2)) begin
          m_pend  = 1'b1;
          m_paddr = m_fpc;
        end
      end
      if (m_q.size() != 0) m_shown = m_q[0];
    end
  endtask

  // ---------------- drive helpers ----------------
  task automatic drive(input bit r, input bit a, input logic [31:0] rd,
                       input bit rv, input logic [31:0] rp, input bit rdy);
    rst            = r;
    imem_ack       = a;
    imem_rdata     = rd;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
  endtask

  task automatic step();
    if (m_known) compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run(input bit r, input bit a, input logic [31:0] rd,
                     input bit rv, input logic [31:0] rp, input bit rdy);
    drive(r, a, rd, rv, rp, rdy);
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    bit          ack;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[12];

  initial begin
    // rst ack rdy | req addr valid pc
    vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0C};

    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
    step();

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rst, vt[i].ack, mem_word(vt[i].e_addr), 1'b0, 32'd0, vt[i].rdy);
      check("tbl_req", {31'd0, imem_req}, {31'd0, vt[i].e_req});
      if (vt[i].e_req) check("tbl_addr", imem_addr, vt[i].e_addr);
      check("tbl_valid", {31'd0, out_valid}, {31'd0, vt[i].e_valid});
      check("tbl_pc", out_pc, vt[i].e_pc);
      if (vt[i].e_valid) check("tbl_opcode", {25'd0, out_opcode}, {25'd0, 7'b0110011});
      if (i == 2) check("wrap_addr0", wrap_addr, 32'hFFFF_FFFC);
      if (i == 3) begin
        check("wrap_addr1", wrap_addr, 32'h0000_0000);
        check("wrap_pc", wrap_pc, 32'hFFFF_FFFC);
      end
      step();
    end

    // Redirect to 0x100 while the fetch of 8 is outstanding; ack 3 cycles later.
    run(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b1, mem_word(32'h0), 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b1, mem_word(32'h4), 1'b0, 32'd0, 1'b1);
    check("pre_redir_addr", imem_addr, 32'h8);
    run(1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("discard_addr", imem_addr, 32'h8);
    step();
    run(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b1, mem_word(32'h8), 1'b0, 32'd0, 1'b1);
    drive(1'b0, 1'b1, mem_word(32'h100), 1'b0, 32'd0, 1'b1);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_novalid", {31'd0, out_valid}, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h100);
    step();

    // Redirect to 0x203 coincident with an ack: data dropped, fetch 0x200.
    run(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b1, mem_word(32'h0), 1'b0, 32'd0, 1'b1);
    run(1'b0, 1'b1, mem_word(32'h4), 1'b1, 32'h203, 1'b1);
    drive(1'b0, 1'b1, mem_word(32'h200), 1'b0, 32'd0, 1'b1);
    check("coinc_addr", imem_addr, 32'h200);
    check("coinc_novalid", {31'd0, out_valid}, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("coinc_pc", out_pc, 32'h200);
    check("coinc_instr", out_instr, mem_word(32'h200));
    step();

`ifdef IF_STALL_CNT_EN
    // Five cycles of a valid head with decode stalled.
    run(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    run(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    run(1'b0, 1'b1, mem_word(32'h0), 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) run(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("stall_five", stall_cnt, 32'd5);
    step();
    run(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("stall_reset", stall_cnt, 32'd0);
    step();
`endif

    // Random traffic: acks may arrive with no request, redirects hit any state.
    run(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      run(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 1) == 1),
          $urandom,
          ($urandom_range(0, 15) == 0),
          $urandom,
          ($urandom_range(0, 2) != 0));
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    compare_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock only.
REQ-003 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory request, held high until acknowledged.
REQ-005 imem_addr  output  32  fetch address; SHALL stay stable while imem_req is high.
REQ-006 imem_ack  input  1  memory acknowledge; SHALL be honoured only while imem_req is high.
REQ-007 imem_rdata  input  32  instruction word, valid in the cycle imem_ack is high.
REQ-008 redirect_valid  input  1  branch/jump redirect from the execute stage.
REQ-009 redirect_pc  input  32  redirect target; bits [1:0] SHALL be forced to 0 internally.
REQ-010 out_valid  output  1  buffer head holds a valid instruction for decode.
REQ-011 out_ready  input  1  decode accepts the head this cycle.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc  output  32  address of out_instr.
REQ-014 out_opcode  output  7  SHALL equal out_instr[6:0]; drives the control unit's opcode input.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {instr, pc}; the head is presented on out_*; a pop occurs on out_valid && out_ready.
REQ-016 FSM states SHALL be IDLE (no request), REQ (request outstanding), and DISCARD (outstanding request whose data is to be dropped).
REQ-017 In IDLE → REQ next cycle when entries + 0 outstanding < 2 after this cycle's pop; imem_req SHALL be high exactly in REQ and DISCARD.
REQ-018 In REQ, on imem_ack: push {imem_rdata, pc}, pc <= pc + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0); stay in REQ if a slot remains after the push and pop, else go to IDLE.
REQ-019 Data pushed on imem_ack at cycle N SHALL appear on out_valid/out_instr at cycle N+1; push and pop in the same cycle SHALL both succeed.
REQ-020 At most one memory request SHALL be outstanding; the FIFO SHALL never overflow; out_valid low means out_instr/out_pc hold their last values.
REQ-021 Redirect SHALL take priority over push and pop: the FIFO is emptied (out_valid low next cycle), and pc <= redirect_pc.
REQ-022 A redirect in REQ without imem_ack SHALL enter DISCARD, keeping the old imem_addr until the ack, whose data is dropped; the next state is then REQ at the new pc.
REQ-023 A redirect in the same cycle as imem_ack SHALL drop that data and go to REQ; imem_addr = redirect_pc next cycle.
REQ-024 A redirect in IDLE SHALL go to REQ; a redirect in DISCARD SHALL update pc and stay in DISCARD.
REQ-025 A handshake (out_valid && out_ready) coincident with a redirect SHALL count as consumed by decode.

Reset
REQ-026 While rst is high: state = IDLE, FIFO empty, pc = RESET_PC, imem_req = 0, out_valid = 0, out_instr = 0, out_pc = 0, stall_cnt = 0 (if present).
REQ-027 The first cycle after rst falls SHALL transition to REQ, so imem_req = 1 with imem_addr = RESET_PC one cycle later.
REQ-028 rst asserted mid-request SHALL abandon the request; a late imem_ack SHALL be ignored because imem_req is 0.

Configuration
REQ-029 Macro IF_STALL_CNT_EN defined: the block SHALL add an output port stall_cnt, 32 bits wide; it SHALL increment each cycle out_valid && !out_ready and saturate at 32'hFFFF_FFFF.
REQ-030 IF_STALL_CNT_EN undefined: the stall_cnt port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Reset release, memory acks every request on the next cycle, out_ready = 1 -> imem_addr sequence 0, 4, 8, …; out_pc matches; out_opcode = out_instr[6:0] (e.g., 0110011 for add).
REQ-032 out_ready = 0 for 10 cycles -> exactly 2 instructions buffered (pc 0, 4), imem_req low, no third fetch; out_ready = 1 -> pops pc 0 then 4 on consecutive cycles.
REQ-033 Redirect to 32'h100 while a request for 8 is outstanding (ack 3 cycles later) -> the word for 8 is never presented; the next imem_addr = 32'h100; out_pc = 32'h100 first.
REQ-034 Redirect to 32'h203 with a coincident ack -> acked data is dropped; imem_addr = 32'h200 next cycle.
REQ-035 RESET_PC = 32'hFFFF_FFFC -> fetches 32'hFFFF_FFFC then 32'h0000_0000.
REQ-036 IF_STALL_CNT_EN defined, out_valid = 1 with out_ready = 0 for 5 cycles -> stall_cnt = 5; rst -> stall_cnt = 0.
